knn_stream_sorter: RTL and testbench
====================================

Name: knn_stream_sorter

Overview:
- Parametrised next-generation k-nearest-neighbour core for the KNN peripheral.
- Latches a DIM-dimensional signed test point, then accepts a stream of labelled data points over a valid/ready handshake.
- Computes each point's squared Euclidean distance serially, one dimension per cycle, and keeps a sorted K-entry neighbour list by insertion.
- Sits behind the software register file. The CPU pushes points into it and reads the list back after completion.

Parameters:
- K, 4, number of neighbour slots (≥1).
- DIM, 2, coordinates per point (≥1).
- COORD_W, 16, signed two's-complement coordinate width.
- LABEL_W, 8, label width.
- DIST_W (localparam), 2*COORD_W+2+$clog2(DIM), distance width. Fixed, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse: clear list, latch test_point, enter RUN.
- test_point  in  DIM*COORD_W  test coordinates; dimension d at bits [d*COORD_W +: COORD_W].
- dp_valid  in  1  data point present.
- dp_ready  out  1  core accepts a point this cycle.
- dp_data  in  DIM*COORD_W  data-point coordinates, same packing as test_point.
- dp_label  in  LABEL_W  data-point label.
- dp_last  in  1  final point of the set; sampled with the handshake.
- busy  out  1  high in any state other than IDLE or DONE.
- nb_valid  out  1  neighbour list final.
- nb_count  out  $clog2(K+1)  number of occupied slots.
- nb_dist  out  K*DIST_W  slot i at [i*DIST_W +: DIST_W]; slot 0 is the nearest.
- nb_label  out  K*LABEL_W  slot labels.

Behaviour:
- Reset (asynchronous, rst low):
  - state=IDLE; dp_ready, busy, nb_valid, nb_count = 0.
  - All nb_dist slots = all-ones; all nb_label slots = 0.
  - Reset asserted mid-operation discards all partial work.
- FSM states: IDLE, WAIT, ACC, INS, DONE.
- start, accepted in any state:
  - Clears the list to its reset values, latches test_point, sets nb_valid=0, goes to WAIT next cycle.
  - start in ACC or INS aborts the in-flight point.
- WAIT:
  - dp_ready=1.
  - On dp_valid&dp_ready: latch dp_data, dp_label, dp_last; clear accumulator; go to ACC.
- ACC (DIM cycles, dimension index d = 0..DIM-1):
  - diff = tp[d] - dp[d], sign-extended to COORD_W+1 bits.
  - acc += diff*diff, no overflow possible at DIST_W.
  - After d = DIM-1, go to INS.
- INS (1 cycle): insert the distance into the list.
  - Position p = first slot i whose entry is unoccupied, or whose dist > new dist.
  - Ties: the existing entry keeps the lower index (strict less-than).
  - Slots p..K-2 shift down by one; slot K-1 is dropped.
  - If no such p exists, the point is discarded and the list is unchanged.
  - nb_count increments, saturating at K.
  - Next state: DONE if the latched last flag is set, else WAIT.
- Throughput: one point per DIM+2 cycles (accept, DIM accumulate, insert). dp_ready=0 in ACC and INS.
- DONE:
  - nb_valid=1; outputs held stable.
  - dp_ready=0; dp_valid is ignored.
  - Leaves DONE only on start or reset.
- IDLE:
  - dp_ready=0; points are ignored.
- Unoccupied slots always read dist all-ones, label 0.

Optional Feature:
- Macro: KNN_VOTE_EN.
- When defined:
  - Adds output vote_label (LABEL_W).
  - Adds state VOTE between INS and DONE, lasting K cycles. Cycle j counts matches of slot j's label across the occupied slots.
  - vote_label = label with the highest count. Ties resolve to the lowest slot index, i.e. the nearest neighbour.
  - nb_valid asserts K cycles later than without the macro.
  - vote_label resets to 0 and is cleared by start.
  - With nb_count = 0, vote_label = 0.
- When undefined: no port, no VOTE state, no added logic.

Test Plan:
- Basic sort. Config K=4, DIM=2, COORD_W=16; test point (0,0).
  - Stimulus, as (point)/label: (3,4)/1, (1,1)/2, (10,0)/3, (0,2)/4, (5,5)/5 with last.
  - Required: nb_dist = 2, 4, 25, 50; nb_label = 2, 4, 1, 5; nb_count = 4; distance 100 discarded; nb_valid=1.
- Under-fill: two points (1,0)/7, (2,0)/8 with last.
  - Required: nb_count = 2; dists 1, 4; slots 2–3 = all-ones / label 0.
- Extreme coordinates: test point (-32768,-32768), point (32767,32767).
  - Required: dist = 8589672450 (DIST_W = 35), no overflow.
- Ties and throughput: three points all at distance 25 with labels 1, 2, 3; dp_valid held high.
  - Required: labels ordered 1, 2, 3; dp_ready pulses exactly once every 4 cycles.
- Abort: start during ACC; then a single point (1,1)/9 with last.
  - Required: nb_count = 1, dist 2, label 9.
  - Separately, rst low mid-stream: all outputs return to reset values immediately.
- KNN_VOTE_EN: labels 3, 5, 3, 5 at distances 1, 2, 4, 9.
  - Required: vote_label = 3 (tie broken by slot 0); nb_valid rises 4 cycles after INS.

Source files
------------

// File: rtl/knn_stream_sorter.sv
// ---------------------------------------------------------------------------
// knn_stream_sorter
//
// Streaming k-nearest-neighbour core. A start pulse clears the neighbour list
// and latches a DIM-dimensional signed test point. Labelled data points then
// arrive over a valid/ready handshake. Each point's squared Euclidean distance
// is accumulated one dimension per cycle and inserted into a K-entry list kept
// sorted by ascending distance (slot 0 is the nearest).
//
// Optional build macro: KNN_VOTE_EN
//   Adds a K-cycle majority vote over the occupied slots after the final
//   insertion and exposes the winning label on vote_label.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start               one-cycle pulse: clear list, latch test_point, run
//   test_point          DIM packed signed coordinates, dim d at [d*COORD_W +:]
//   dp_valid/dp_ready   data-point handshake
//   dp_data, dp_label   data-point coordinates (same packing) and label
//   dp_last             final point of the set, sampled with the handshake
//   busy                high in any state other than IDLE or DONE
//   nb_valid            neighbour list is final
//   nb_count            number of occupied slots
//   nb_dist, nb_label   packed slot distances / labels, slot i at [i*W +: W]
//   vote_label          (KNN_VOTE_EN only) most frequent label, ties -> nearest
// ---------------------------------------------------------------------------
module knn_stream_sorter #(
    parameter int K       = 4,
    parameter int DIM     = 2,
    parameter int COORD_W = 16,
    parameter int LABEL_W = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [DIM*COORD_W-1:0]                    test_point,
    input  logic                                      dp_valid,
    output logic                                      dp_ready,
    input  logic [DIM*COORD_W-1:0]                    dp_data,
    input  logic [LABEL_W-1:0]                        dp_label,
    input  logic                                      dp_last,
    output logic                                      busy,
    output logic                                      nb_valid,
    output logic [$clog2(K+1)-1:0]                    nb_count,
    output logic [K*(2*COORD_W+2+$clog2(DIM))-1:0]    nb_dist,
    output logic [K*LABEL_W-1:0]                      nb_label
`ifdef KNN_VOTE_EN
    ,
    output logic [LABEL_W-1:0]                        vote_label
`endif
);

    localparam int DIST_W = 2*COORD_W + 2 + $clog2(DIM);
    localparam int CNT_W  = $clog2(K+1);
    localparam int D_W    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int KI_W   = (K > 1) ? $clog2(K) : 1;
    localparam int SQ_W   = 2*COORD_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACC,
        S_INS,
`ifdef KNN_VOTE_EN
        S_VOTE,
`endif
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DIM*COORD_W-1:0] tp_q, tp_d;
    logic [DIM*COORD_W-1:0] dp_q, dp_d;
    logic [LABEL_W-1:0]     lbl_q, lbl_d;
    logic                   last_q, last_d;
    logic [DIST_W-1:0]      acc_q, acc_d;
    logic [D_W-1:0]         dim_q, dim_d;
    logic [DIST_W-1:0]      nb_dist_q  [K];
    logic [DIST_W-1:0]      nb_dist_d  [K];
    logic [LABEL_W-1:0]     nb_label_q [K];
    logic [LABEL_W-1:0]     nb_label_d [K];
    logic [CNT_W-1:0]       nb_count_q, nb_count_d;

    // Squared difference of the current dimension.
    logic [COORD_W-1:0]     tp_coord, dp_coord;
    logic signed [COORD_W:0] diff;
    logic signed [SQ_W-1:0] diff_ext, sq_s;
    logic [SQ_W-1:0]        sq;

    // Insertion point search.
    logic                   ins_found;
    logic [CNT_W-1:0]       ins_pos;

`ifdef KNN_VOTE_EN
    logic [KI_W-1:0]        vidx_q, vidx_d;
    logic [CNT_W-1:0]       best_cnt_q, best_cnt_d;
    logic [LABEL_W-1:0]     best_label_q, best_label_d;
    logic [LABEL_W-1:0]     vote_q, vote_d;
    logic [LABEL_W-1:0]     cur_label;
    logic [CNT_W-1:0]       match_cnt;
    logic                   best_upd;
`endif

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        tp_coord = tp_q[dim_q*COORD_W +: COORD_W];
        dp_coord = dp_q[dim_q*COORD_W +: COORD_W];
        // One extra bit so the difference of two extremes cannot wrap.
        diff     = {tp_coord[COORD_W-1], tp_coord} - {dp_coord[COORD_W-1], dp_coord};
        diff_ext = {{(COORD_W+1){diff[COORD_W]}}, diff};
        sq_s     = diff_ext * diff_ext;
        sq       = sq_s;
    end

    // First slot that is empty or holds a strictly larger distance; equal
    // distances leave the older entry in front.
    always_comb begin
        ins_found = 1'b0;
        ins_pos   = '0;
        for (int i = 0; i < K; i++) begin
            if (!ins_found && ((CNT_W'(i) >= nb_count_q) || (nb_dist_q[i] > acc_q))) begin
                ins_found = 1'b1;
                ins_pos   = CNT_W'(i);
            end
        end
    end

`ifdef KNN_VOTE_EN
    // Occurrences of slot vidx's label among the occupied slots.
    always_comb begin
        cur_label = '0;
        match_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (KI_W'(i) == vidx_q) cur_label = nb_label_q[i];
        end
        for (int i = 0; i < K; i++) begin
            if ((CNT_W'(i) < nb_count_q) && (nb_label_q[i] == cur_label))
                match_cnt = match_cnt + CNT_W'(1);
        end
        // Strictly greater keeps the earliest (nearest) slot on a tie.
        best_upd = (CNT_W'(vidx_q) < nb_count_q) && (match_cnt > best_cnt_q);
    end
`endif

    always_comb begin
        state_d    = state_q;
        tp_d       = tp_q;
        dp_d       = dp_q;
        lbl_d      = lbl_q;
        last_d     = last_q;
        acc_d      = acc_q;
        dim_d      = dim_q;
        nb_dist_d  = nb_dist_q;
        nb_label_d = nb_label_q;
        nb_count_d = nb_count_q;
`ifdef KNN_VOTE_EN
        vidx_d       = vidx_q;
        best_cnt_d   = best_cnt_q;
        best_label_d = best_label_q;
        vote_d       = vote_q;
`endif

        unique case (state_q)
            S_WAIT: begin
                // dp_ready is high throughout WAIT, so valid alone completes
                // the handshake.
                if (dp_valid) begin
                    dp_d    = dp_data;
                    lbl_d   = dp_label;
                    last_d  = dp_last;
                    acc_d   = '0;
                    dim_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = acc_q + DIST_W'(sq);
                if (dim_q == D_W'(DIM-1)) state_d = S_INS;
                else                      dim_d   = dim_q + D_W'(1);
            end
            S_INS: begin
                if (ins_found) begin
                    for (int i = 1; i < K; i++) begin
                        if (CNT_W'(i) > ins_pos) begin
                            nb_dist_d[i]  = nb_dist_q[i-1];
                            nb_label_d[i] = nb_label_q[i-1];
                        end
                    end
                    for (int i = 0; i < K; i++) begin
                        if (CNT_W'(i) == ins_pos) begin
                            nb_dist_d[i]  = acc_q;
                            nb_label_d[i] = lbl_q;
                        end
                    end
                    if (nb_count_q != CNT_W'(K)) nb_count_d = nb_count_q + CNT_W'(1);
                end
`ifdef KNN_VOTE_EN
                vidx_d       = '0;
                best_cnt_d   = '0;
                best_label_d = '0;
                state_d      = last_q ? S_VOTE : S_WAIT;
`else
                state_d      = last_q ? S_DONE : S_WAIT;
`endif
            end
`ifdef KNN_VOTE_EN
            S_VOTE: begin
                if (best_upd) begin
                    best_cnt_d   = match_cnt;
                    best_label_d = cur_label;
                end
                if (vidx_q == KI_W'(K-1)) begin
                    vote_d  = best_upd ? cur_label : best_label_q;
                    state_d = S_DONE;
                end else begin
                    vidx_d = vidx_q + KI_W'(1);
                end
            end
`endif
            S_IDLE, S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        // start wins in every state and abandons any in-flight point.
        if (start) begin
            state_d    = S_WAIT;
            tp_d       = test_point;
            nb_count_d = '0;
            for (int i = 0; i < K; i++) begin
                nb_dist_d[i]  = '1;
                nb_label_d[i] = '0;
            end
`ifdef KNN_VOTE_EN
            vote_d = '0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tp_q       <= '0;
            dp_q       <= '0;
            lbl_q      <= '0;
            last_q     <= 1'b0;
            acc_q      <= '0;
            dim_q      <= '0;
            nb_count_q <= '0;
            // NOTE: the neighbour slots are flops with a defined empty value
            // (all-ones / 0), not a RAM, so they are reset explicitly.
            for (int i = 0; i < K; i++) begin
                nb_dist_q[i]  <= '1;
                nb_label_q[i] <= '0;
            end
`ifdef KNN_VOTE_EN
            vidx_q       <= '0;
            best_cnt_q   <= '0;
            best_label_q <= '0;
            vote_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tp_q       <= tp_d;
            dp_q       <= dp_d;
            lbl_q      <= lbl_d;
            last_q     <= last_d;
            acc_q      <= acc_d;
            dim_q      <= dim_d;
            nb_count_q <= nb_count_d;
            nb_dist_q  <= nb_dist_d;
            nb_label_q <= nb_label_d;
`ifdef KNN_VOTE_EN
            vidx_q       <= vidx_d;
            best_cnt_q   <= best_cnt_d;
            best_label_q <= best_label_d;
            vote_q       <= vote_d;
`endif
        end
    end

    always_comb begin
        dp_ready = (state_q == S_WAIT);
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        nb_valid = (state_q == S_DONE);
        nb_count = nb_count_q;
        nb_dist  = '0;
        nb_label = '0;
        for (int i = 0; i < K; i++) begin
            nb_dist[i*DIST_W +: DIST_W]    = nb_dist_q[i];
            nb_label[i*LABEL_W +: LABEL_W] = nb_label_q[i];
        end
    end

`ifdef KNN_VOTE_EN
    assign vote_label = vote_q;
`endif

endmodule

// File: tb/tb_knn_stream_sorter.sv
// ---------------------------------------------------------------------------
// tb_knn_stream_sorter
//
// Directed scenarios plus randomized point sets for knn_stream_sorter
// (K=4, DIM=2, COORD_W=16, LABEL_W=8). Expected lists come from a sorted-queue
// reference model; the optional vote is modelled by label frequency counting.
// ---------------------------------------------------------------------------
module tb_knn_stream_sorter;

    localparam int K       = 4;
    localparam int DIM     = 2;
    localparam int COORD_W = 16;
    localparam int LABEL_W = 8;
    localparam int DIST_W  = 2*COORD_W + 2 + $clog2(DIM);
    localparam int CNT_W   = $clog2(K+1);
    localparam logic [DIST_W-1:0] DIST_EMPTY = '1;
`ifdef KNN_VOTE_EN
    localparam int VOTE_LAT = K;
`else
    localparam int VOTE_LAT = 0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [DIM*COORD_W-1:0]    test_point;
    logic                      dp_valid;
    logic                      dp_ready;
    logic [DIM*COORD_W-1:0]    dp_data;
    logic [LABEL_W-1:0]        dp_label;
    logic                      dp_last;
    logic                      busy;
    logic                      nb_valid;
    logic [CNT_W-1:0]          nb_count;
    logic [K*DIST_W-1:0]       nb_dist;
    logic [K*LABEL_W-1:0]      nb_label;
`ifdef KNN_VOTE_EN
    logic [LABEL_W-1:0]        vote_label;
`endif

    knn_stream_sorter #(.K(K), .DIM(DIM), .COORD_W(COORD_W), .LABEL_W(LABEL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .test_point (test_point),
        .dp_valid   (dp_valid),
        .dp_ready   (dp_ready),
        .dp_data    (dp_data),
        .dp_label   (dp_label),
        .dp_last    (dp_last),
        .busy       (busy),
        .nb_valid   (nb_valid),
        .nb_count   (nb_count),
        .nb_dist    (nb_dist),
        .nb_label   (nb_label)
`ifdef KNN_VOTE_EN
        ,
        .vote_label (vote_label)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: neighbour list as sorted queues.
    longint m_dist[$];
    int     m_lab[$];
    int     tp_x, tp_y;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        m_dist.delete();
        m_lab.delete();
    endfunction

    // Insert after any equal distance (older wins ties), keep only K nearest.
    function automatic void model_add(input int px, input int py, input int lab);
        longint dx, dy, d;
        int     idx;
        dx  = longint'(tp_x) - longint'(px);
        dy  = longint'(tp_y) - longint'(py);
        d   = dx*dx + dy*dy;
        idx = m_dist.size();
        for (int i = 0; i < m_dist.size(); i++) begin
            if (m_dist[i] > d) begin
                idx = i;
                break;
            end
        end
        m_dist.insert(idx, d);
        m_lab.insert(idx, lab);
        if (m_dist.size() > K) begin
            void'(m_dist.pop_back());
            void'(m_lab.pop_back());
        end
    endfunction

    // Most frequent label; on equal counts the nearer slot's label wins.
    function automatic int model_vote();
        int best, best_lab, cnt;
        best = 0;
        best_lab = 0;
        for (int j = 0; j < m_lab.size(); j++) begin
            cnt = 0;
            foreach (m_lab[i]) if (m_lab[i] == m_lab[j]) cnt++;
            if (cnt > best) begin
                best = cnt;
                best_lab = m_lab[j];
            end
        end
        return best_lab;
    endfunction

    task automatic compare_list(input string tag);
        logic [63:0] ed, el;
        check($sformatf("%s count", tag), 64'(nb_count), 64'(m_dist.size()));
        for (int i = 0; i < K; i++) begin
            ed = (i < m_dist.size()) ? 64'(m_dist[i]) : 64'(DIST_EMPTY);
            el = (i < m_lab.size())  ? 64'(m_lab[i])  : 64'd0;
            check($sformatf("%s dist[%0d]", tag, i), 64'(nb_dist[i*DIST_W +: DIST_W]), ed);
            check($sformatf("%s label[%0d]", tag, i), 64'(nb_label[i*LABEL_W +: LABEL_W]), el);
        end
    endtask

    // Called at a negedge; returns at a negedge with start low, DUT in WAIT.
    task automatic do_start(input int x, input int y);
        tp_x = x;
        tp_y = y;
        model_clear();
        test_point = {16'(y), 16'(x)};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one point; returns at the negedge right after it was accepted.
    task automatic push(input int x, input int y, input int lab, input bit last);
        int waited;
        waited   = 0;
        dp_valid = 1'b1;
        dp_data  = {16'(y), 16'(x)};
        dp_label = LABEL_W'(lab);
        dp_last  = last;
        while (!dp_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("dp_ready within bound", 64'(dp_ready), 64'd1);
        @(negedge clk);
        dp_valid = 1'b0;
        dp_last  = 1'b0;
        model_add(x, y, lab);
    endtask

    // Waits for nb_valid; optionally checks the latency from the last accept.
    task automatic wait_done(input string tag, input bit chk_lat);
        int lat;
        lat = 0;
        while (!nb_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " nb_valid"}, 64'(nb_valid), 64'd1);
        if (chk_lat) check({tag, " latency"}, 64'(lat), 64'(DIM + 1 + VOTE_LAT));
    endtask

    task automatic check_vote(input string tag);
`ifdef KNN_VOTE_EN
        check({tag, " vote"}, 64'(vote_label), 64'(model_vote()));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        model_clear();
        check({tag, " dp_ready"}, 64'(dp_ready), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " nb_valid"}, 64'(nb_valid), 64'd0);
        compare_list(tag);
        check_vote(tag);
    endtask

    int ready_at[$];
    int n_acc, cyc, n_pts, px, py;
    logic signed [15:0] rx, ry;

    initial begin
        rst = 1'b0; start = 1'b0; test_point = '0;
        dp_valid = 1'b0; dp_data = '0; dp_label = '0; dp_last = 1'b0;
        tp_x = 0; tp_y = 0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;

        // IDLE ignores points.
        dp_valid = 1'b1; dp_data = {16'd1, 16'd1}; dp_label = 8'd9;
        repeat (3) @(negedge clk);
        check("idle dp_ready", 64'(dp_ready), 64'd0);
        check("idle nb_count", 64'(nb_count), 64'd0);
        dp_valid = 1'b0;

        // Basic sort: distance 100 falls off the end.
        do_start(0, 0);
        check("start busy", 64'(busy), 64'd1);
        push(3, 4, 1, 0);
        push(1, 1, 2, 0);
        push(10, 0, 3, 0);
        push(0, 2, 4, 0);
        push(5, 5, 5, 1);
        wait_done("basic", 1'b1);
        compare_list("basic");
        check("basic slot3 dist", 64'(nb_dist[3*DIST_W +: DIST_W]), 64'd50);
        check("basic slot0 label", 64'(nb_label[7:0]), 64'd2);
        check("basic busy", 64'(busy), 64'd0);

        // DONE holds and ignores further points.
        dp_valid = 1'b1; dp_data = {16'd0, 16'd0}; dp_label = 8'd6;
        repeat (4) @(negedge clk);
        check("done dp_ready", 64'(dp_ready), 64'd0);
        check("done nb_valid", 64'(nb_valid), 64'd1);
        compare_list("done hold");
        dp_valid = 1'b0;

        // Under-fill.
        do_start(0, 0);
        check("restart nb_valid", 64'(nb_valid), 64'd0);
        check("restart nb_count", 64'(nb_count), 64'd0);
        push(1, 0, 7, 0);
        push(2, 0, 8, 1);
        wait_done("underfill", 1'b1);
        compare_list("underfill");

        // Extreme coordinates.
        do_start(-32768, -32768);
        push(32767, 32767, 11, 1);
        wait_done("extreme", 1'b1);
        check("extreme dist", 64'(nb_dist[DIST_W-1:0]), 64'd8589672450);
        compare_list("extreme");

        // Ties with dp_valid held high: order of arrival, one accept per 4 cycles.
        do_start(0, 0);
        ready_at.delete();
        n_acc = 0; cyc = 0;
        dp_valid = 1'b1; dp_data = {16'd4, 16'd3}; dp_label = 8'd1; dp_last = 1'b0;
        model_add(3, 4, 1);
        while (n_acc < 3 && cyc < 60) begin
            if (dp_ready) begin
                ready_at.push_back(cyc);
                n_acc++;
            end
            @(negedge clk);
            cyc++;
            if (n_acc == 1 && ready_at[0] == cyc - 1) begin
                dp_data = {16'd0, 16'd5}; dp_label = 8'd2;
                model_add(5, 0, 2);
            end else if (n_acc == 2 && ready_at[1] == cyc - 1) begin
                dp_data = {16'hFFFB, 16'd0}; dp_label = 8'd3; dp_last = 1'b1;
                model_add(0, -5, 3);
            end
        end
        dp_valid = 1'b0; dp_last = 1'b0;
        check("ties accepts", 64'(n_acc), 64'd3);
        if (n_acc == 3) begin
            check("ties ready gap 1", 64'(ready_at[1] - ready_at[0]), 64'(DIM + 2));
            check("ties ready gap 2", 64'(ready_at[2] - ready_at[1]), 64'(DIM + 2));
        end
        wait_done("ties", 1'b0);
        check("ties label0", 64'(nb_label[7:0]), 64'd1);
        check("ties label1", 64'(nb_label[15:8]), 64'd2);
        check("ties label2", 64'(nb_label[23:16]), 64'd3);
        compare_list("ties");

        // Abort: start arrives while the first point is accumulating.
        do_start(0, 0);
        push(100, 100, 77, 0);
        check("abort in ACC busy", 64'(busy), 64'd1);
        do_start(0, 0);
        push(1, 1, 9, 1);
        wait_done("abort", 1'b1);
        compare_list("abort");

        // Asynchronous reset mid-stream.
        do_start(0, 0);
        push(3, 4, 1, 0);
        repeat (3) @(negedge clk);
        push(6, 8, 2, 0);
        rst = 1'b0;
        #1;
        check_reset_state("rst midstream");
        @(negedge clk);
        rst = 1'b1;

        // Vote scenario: labels 3,5,3,5 at distances 1,2,4,9.
        do_start(0, 0);
        push(1, 0, 3, 0);
        push(1, 1, 5, 0);
        push(2, 0, 3, 0);
        push(3, 0, 5, 1);
        wait_done("vote", 1'b1);
        compare_list("vote");
`ifdef KNN_VOTE_EN
        check("vote label", 64'(vote_label), 64'd3);
        do_start(0, 0);
        check("vote cleared by start", 64'(vote_label), 64'd0);
        @(negedge clk);
`endif

        // Randomized sets; the last one uses the full coordinate range.
        for (int s = 0; s < 6; s++) begin
            if (s < 5) do_start(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10);
            else begin
                rx = 16'($urandom);
                ry = 16'($urandom);
                do_start(int'(rx), int'(ry));
            end
            n_pts = int'($urandom_range(1, 7));
            for (int p = 0; p < n_pts; p++) begin
                if (s < 5) begin
                    px = int'($urandom_range(0, 12)) - 6;
                    py = int'($urandom_range(0, 12)) - 6;
                end else begin
                    rx = 16'($urandom);
                    ry = 16'($urandom);
                    px = int'(rx);
                    py = int'(ry);
                end
                push(px, py, int'($urandom_range(0, 3)), p == n_pts - 1);
            end
            wait_done($sformatf("rand%0d", s), 1'b1);
            compare_list($sformatf("rand%0d", s));
            check_vote($sformatf("rand%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
